// File: rtl/pe_pkg.sv
// Shared definitions for the double-buffered systolic processing element.
package pe_pkg;

  localparam int unsigned PE_DATA_WIDTH = 16;
  localparam int unsigned PE_ACC_WIDTH  = 32;

  typedef enum logic [1:0] {
    PE_PASS   = 2'd0,
    PE_WS_MAC = 2'd1,
    PE_OS_ACC = 2'd2,
    PE_RSVD   = 2'd3
  } pe_mode_e;

endpackage

// File: rtl/pe_sat_add.sv
// Signed adder with one guard bit; clamps or wraps on overflow.
module pe_sat_add #(
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum_c,
  output logic             ovf_c
);

  logic [WIDTH:0] wide;

  assign wide = {a[WIDTH-1], a} + {b[WIDTH-1], b};

  // Guard bit disagreeing with the top result bit means the sum left the signed range.
  always_comb begin
    ovf_c = wide[WIDTH] ^ wide[WIDTH-1];
    sum_c = wide[WIDTH-1:0];
    if (ovf_c && SATURATE) begin
      sum_c = wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/proc_elem_dbuf.sv
// Systolic-array processing element with shadow/active weight double buffer,
// weight-stationary MAC and output-stationary accumulate modes.
module proc_elem_dbuf
  import pe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PE_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH  = PE_ACC_WIDTH,
  parameter bit          SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_left,
  input  logic                  in_left_valid,
  input  logic [ACC_WIDTH-1:0]  in_top,
  input  logic                  in_top_valid,
  input  logic                  weight_load,
  input  logic                  weight_swap,
  input  logic [1:0]            mode,
  input  logic                  acc_clear,
  input  logic                  drain,
  output logic [DATA_WIDTH-1:0] out_right,
  output logic                  out_right_valid,
  output logic [ACC_WIDTH-1:0]  out_down,
  output logic                  out_down_valid,
  output logic                  shadow_full,
  output logic                  ovf
);

  localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

  logic [DATA_WIDTH-1:0]        shadow;
  logic [DATA_WIDTH-1:0]        active;
  logic [ACC_WIDTH-1:0]         acc;
  logic signed [PROD_WIDTH-1:0] product;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic [ACC_WIDTH-1:0]         mac_sum_c;
  logic                         mac_ovf_c;
  logic [ACC_WIDTH-1:0]         acc_sum_c;
  logic                         acc_ovf_c;
  logic                         swap_ok;

  // Product always uses the active weight held before this edge.
  assign product  = PROD_WIDTH'($signed(active)) * PROD_WIDTH'($signed(in_left));
  assign prod_ext = ACC_WIDTH'(product);
  assign swap_ok  = weight_swap && shadow_full;

  pe_sat_add #(.WIDTH(ACC_WIDTH), .SATURATE(SATURATE)) u_mac_add (
    .a     (in_top),
    .b     (prod_ext),
    .sum_c (mac_sum_c),
    .ovf_c (mac_ovf_c)
  );

  pe_sat_add #(.WIDTH(ACC_WIDTH), .SATURATE(SATURATE)) u_acc_add (
    .a     (acc),
    .b     (prod_ext),
    .sum_c (acc_sum_c),
    .ovf_c (acc_ovf_c)
  );

  // Activation forward, independent of mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_right       <= '0;
      out_right_valid <= 1'b0;
    end else begin
      out_right       <= in_left;
      out_right_valid <= in_left_valid;
    end
  end

  // Weight double buffer; a load in the same cycle as a swap refills the shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow      <= '0;
      active      <= '0;
      shadow_full <= 1'b0;
    end else begin
      if (swap_ok) begin
        active <= shadow;
      end
      if (weight_load) begin
        shadow      <= in_top[DATA_WIDTH-1:0];
        shadow_full <= 1'b1;
      end else if (swap_ok) begin
        shadow_full <= 1'b0;
      end
    end
  end

  // Partial-sum path and accumulator; acc_clear is applied last so it wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_down       <= '0;
      out_down_valid <= 1'b0;
      acc            <= '0;
      ovf            <= 1'b0;
    end else begin
      out_down_valid <= 1'b0;
      case (mode)
        PE_WS_MAC: begin
          if (in_left_valid && in_top_valid) begin
            out_down       <= mac_sum_c;
            out_down_valid <= 1'b1;
            if (mac_ovf_c) begin
              ovf <= 1'b1;
            end
          end
        end
        PE_OS_ACC: begin
          if (!acc_clear) begin
            if (drain) begin
              out_down       <= acc;
              out_down_valid <= 1'b1;
              acc            <= in_left_valid ? prod_ext : '0;
            end else if (in_left_valid) begin
              acc <= acc_sum_c;
              if (acc_ovf_c) begin
                ovf <= 1'b1;
              end
            end
          end
        end
        default: begin
          out_down       <= in_top;
          out_down_valid <= in_top_valid;
        end
      endcase
      if (acc_clear) begin
        acc <= '0;
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_proc_elem_dbuf.sv
// Directed and randomized checks of proc_elem_dbuf against a longint reference model.
module tb_proc_elem_dbuf;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] in_left;
  logic        in_left_valid;
  logic [31:0] in_top;
  logic        in_top_valid;
  logic        weight_load;
  logic        weight_swap;
  logic [1:0]  mode;
  logic        acc_clear;
  logic        drain;
  logic [15:0] out_right;
  logic        out_right_valid;
  logic [31:0] out_down;
  logic        out_down_valid;
  logic        shadow_full;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  // Reference state
  longint      m_active, m_shadow, m_acc;
  bit          m_full, m_ovf, m_down_v, m_right_v;
  logic [31:0] m_down;
  logic [15:0] m_right;

  proc_elem_dbuf dut (
    .clk             (clk),
    .reset           (reset),
    .in_left         (in_left),
    .in_left_valid   (in_left_valid),
    .in_top          (in_top),
    .in_top_valid    (in_top_valid),
    .weight_load     (weight_load),
    .weight_swap     (weight_swap),
    .mode            (mode),
    .acc_clear       (acc_clear),
    .drain           (drain),
    .out_right       (out_right),
    .out_right_valid (out_right_valid),
    .out_down        (out_down),
    .out_down_valid  (out_down_valid),
    .shadow_full     (shadow_full),
    .ovf             (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed 32-bit result of an exact sum: clamp (saturating build) with overflow flag.
  task automatic sat(input longint s, output longint r, output bit o);
    o = (s > MAXV) || (s < MINV);
    r = s;
    if (s > MAXV) r = MAXV;
    if (s < MINV) r = MINV;
  endtask

  task automatic model();
    longint l, prod, r;
    bit o, swp;
    logic [15:0] w;
    if (reset) begin
      m_active = 0; m_shadow = 0; m_acc = 0; m_full = 0; m_ovf = 0;
      m_down = '0; m_down_v = 0; m_right = '0; m_right_v = 0;
    end else begin
      l = longint'($signed(in_left));
      prod = m_active * l;
      m_right = in_left;
      m_right_v = in_left_valid;
      m_down_v = 0;
      case (mode)
        2'd1: if (in_left_valid && in_top_valid) begin
          sat(longint'($signed(in_top)) + prod, r, o);
          m_down = r[31:0];
          m_down_v = 1;
          if (o) m_ovf = 1;
        end
        2'd2: if (!acc_clear) begin
          if (drain) begin
            m_down = m_acc[31:0];
            m_down_v = 1;
            m_acc = in_left_valid ? prod : 0;
          end else if (in_left_valid) begin
            sat(m_acc + prod, r, o);
            m_acc = r;
            if (o) m_ovf = 1;
          end
        end
        default: begin
          m_down = in_top;
          m_down_v = in_top_valid;
        end
      endcase
      if (acc_clear) begin
        m_acc = 0;
        m_ovf = 0;
      end
      swp = weight_swap && m_full;
      if (swp) m_active = m_shadow;
      if (weight_load) begin
        w = in_top[15:0];
        m_shadow = longint'($signed(w));
        m_full = 1;
      end else if (swp) begin
        m_full = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare all outputs after the edge.
  task automatic cyc(input bit rst, input logic [1:0] m, input bit lv, input logic [15:0] l,
                     input bit tv, input logic [31:0] t, input bit wl, input bit ws,
                     input bit clr, input bit dr);
    reset = rst; mode = m; in_left_valid = lv; in_left = l; in_top_valid = tv; in_top = t;
    weight_load = wl; weight_swap = ws; acc_clear = clr; drain = dr;
    model();
    @(posedge clk);
    #1;
    check("out_right", 64'(out_right), 64'(m_right));
    check("out_right_valid", 64'(out_right_valid), 64'(m_right_v));
    check("out_down", 64'(out_down), 64'(m_down));
    check("out_down_valid", 64'(out_down_valid), 64'(m_down_v));
    check("shadow_full", 64'(shadow_full), 64'(m_full));
    check("ovf", 64'(ovf), 64'(m_ovf));
  endtask

  initial begin
    // Reset state
    cyc(1, 2'd0, 0, 16'd0, 0, 32'd0, 0, 0, 0, 0);
    check("rst_out_down", 64'(out_down), 64'd0);
    check("rst_shadow_full", 64'(shadow_full), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);

    // Load 3, swap, MAC 10 + 3*4
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd3, 1, 0, 0, 0);
    check("load_full", 64'(shadow_full), 64'd1);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 1, 0, 0);
    check("swap_empty", 64'(shadow_full), 64'd0);
    cyc(0, 2'd1, 1, 16'd4, 1, 32'd10, 0, 0, 0, 0);
    check("mac_22", 64'(out_down), 64'd22);
    check("mac_22_valid", 64'(out_down_valid), 64'd1);
    cyc(0, 2'd1, 1, 16'd4, 0, 32'd10, 0, 0, 0, 0);
    check("mac_hold", 64'(out_down), 64'd22);
    check("mac_hold_valid", 64'(out_down_valid), 64'd0);

    // Double load, swap twice; active must be 7
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd5, 1, 0, 0, 0);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd7, 1, 0, 0, 0);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 1, 0, 0);
    check("dbl_swap_full", 64'(shadow_full), 64'd0);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 1, 0, 0);
    cyc(0, 2'd1, 1, 16'd1, 1, 32'd0, 0, 0, 0, 0);
    check("active_7", 64'(out_down), 64'd7);

    // Swap in the same cycle as MAC still uses old weight (7), then new (9)
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd9, 1, 0, 0, 0);
    cyc(0, 2'd1, 1, 16'd2, 1, 32'd0, 0, 1, 0, 0);
    check("swap_old_weight", 64'(out_down), 64'd14);
    cyc(0, 2'd1, 1, 16'd2, 1, 32'd0, 0, 0, 0, 0);
    check("swap_new_weight", 64'(out_down), 64'd18);

    // OS_ACC with weight 2: 2+4+6 then drain
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd2, 1, 0, 0, 0);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 1, 0, 0);
    cyc(0, 2'd2, 0, 16'd0, 0, 32'd0, 0, 0, 1, 0);
    for (int i = 1; i <= 3; i++) cyc(0, 2'd2, 1, 16'(i), 0, 32'd0, 0, 0, 0, 0);
    check("os_no_valid", 64'(out_down_valid), 64'd0);
    cyc(0, 2'd2, 0, 16'd0, 0, 32'd0, 0, 0, 0, 1);
    check("drain_12", 64'(out_down), 64'd12);
    check("drain_valid", 64'(out_down_valid), 64'd1);
    cyc(0, 2'd2, 0, 16'd0, 0, 32'd0, 0, 0, 0, 0);
    check("drain_one_cycle", 64'(out_down_valid), 64'd0);
    cyc(0, 2'd2, 0, 16'd0, 0, 32'd0, 0, 0, 0, 1);
    check("acc_zeroed", 64'(out_down), 64'd0);
    // Clear beats drain
    cyc(0, 2'd2, 1, 16'd5, 0, 32'd0, 0, 0, 0, 0);
    cyc(0, 2'd2, 0, 16'd0, 0, 32'd0, 0, 0, 1, 1);
    check("clear_no_drain", 64'(out_down_valid), 64'd0);

    // Saturation
    cyc(0, 2'd0, 0, 16'd0, 0, 32'h0000_7FFF, 1, 0, 0, 0);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 1, 0, 0);
    cyc(0, 2'd1, 1, 16'h7FFF, 1, 32'h7FFF_FFF0, 0, 0, 0, 0);
    check("sat_max", 64'(out_down), 64'h7FFF_FFFF);
    check("sat_ovf", 64'(ovf), 64'd1);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 0, 0, 0);
    check("ovf_sticky", 64'(ovf), 64'd1);
    cyc(0, 2'd0, 0, 16'd0, 0, 32'd0, 0, 0, 1, 0);
    check("ovf_cleared", 64'(ovf), 64'd0);
    cyc(0, 2'd1, 1, 16'h8001, 1, 32'h8000_0000, 0, 0, 0, 0);
    check("sat_min", 64'(out_down), 64'h8000_0000);

    // Reset mid-accumulation with load pending
    cyc(0, 2'd2, 1, 16'd5, 0, 32'd0, 0, 0, 0, 0);
    cyc(0, 2'd2, 1, 16'd5, 0, 32'd0, 0, 0, 0, 0);
    cyc(1, 2'd2, 1, 16'd5, 1, 32'h1234, 1, 0, 0, 1);
    check("mid_rst_down", 64'(out_down), 64'd0);
    check("mid_rst_right", 64'(out_right), 64'd0);
    check("mid_rst_full", 64'(shadow_full), 64'd0);
    cyc(0, 2'd2, 0, 16'd0, 0, 32'd0, 0, 0, 0, 1);
    check("mid_rst_acc", 64'(out_down), 64'd0);

    // PASS
    cyc(0, 2'd0, 1, 16'd9, 1, 32'h0000_ABCD, 0, 0, 0, 0);
    check("pass_down", 64'(out_down), 64'h0000_ABCD);
    check("pass_right", 64'(out_right), 64'd9);
    cyc(0, 2'd3, 0, 16'd0, 1, 32'h1357_2468, 0, 0, 0, 0);
    check("rsvd_pass", 64'(out_down), 64'h1357_2468);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      logic [31:0] t;
      t = $urandom;
      if ($urandom_range(0, 3) == 0) t = {2'b01, 14'h3FFF, t[15:0]};
      if ($urandom_range(0, 3) == 0) t = {2'b10, 14'h0000, t[15:0]};
      cyc(($urandom_range(0, 59) == 0), 2'($urandom_range(0, 3)),
          1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)), t,
          ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 14) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/proc_elem_dbuf.md
PROC_ELEM_DBUF -- requirements
Module: proc_elem_dbuf

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed operand and weight width.
REQ-002 Parameter ACC_WIDTH, default 32, signed partial-sum and accumulator width; SHALL be at least 2*DATA_WIDTH.
REQ-003 Parameter SATURATE, default 1; 1 clamps results, 0 wraps them.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 in_left  in  DATA_WIDTH  signed activation from the left neighbour.
REQ-007 in_left_valid  in  1  qualifies in_left.
REQ-008 in_top  in  ACC_WIDTH  partial sum from above; low DATA_WIDTH bits carry the weight during load.
REQ-009 in_top_valid  in  1  qualifies in_top as a partial sum.
REQ-010 weight_load  in  1  writes the shadow weight.
REQ-011 weight_swap  in  1  promotes shadow weight to active.
REQ-012 mode  in  2  0=PASS, 1=WS_MAC, 2=OS_ACC, 3=reserved.
REQ-013 acc_clear  in  1  zeroes accumulator and overflow flag.
REQ-014 drain  in  1  emits the accumulator in OS_ACC.
REQ-015 out_right / out_right_valid  out  DATA_WIDTH / 1  registered activation forward.
REQ-016 out_down / out_down_valid  out  ACC_WIDTH / 1  registered partial-sum output.
REQ-017 shadow_full  out  1  shadow holds a weight not yet swapped.
REQ-018 ovf  out  1  sticky saturation/overflow flag.

Function
REQ-019 out_right/out_right_valid SHALL equal in_left/in_left_valid one cycle later, in every mode.
REQ-020 weight_load SHALL set shadow <= in_top[DATA_WIDTH-1:0] and shadow_full <= 1.
REQ-021 weight_swap with shadow_full=1 SHALL set active <= shadow and shadow_full <= 0; with shadow_full=0 it SHALL be ignored.
REQ-022 Simultaneous load and swap with shadow_full=1: active <= old shadow, shadow <= new value, shadow_full stays 1; with shadow_full=0: load only.
REQ-023 product = active * in_left, full 2*DATA_WIDTH signed, sign-extended before addition.
REQ-024 Sums SHALL be computed at ACC_WIDTH+1 bits; on overflow, SATURATE=1 clamps to the signed max/min and SATURATE=0 keeps the low ACC_WIDTH bits; either way ovf <= 1.
REQ-025 PASS (and reserved 3): out_down <= in_top and out_down_valid <= in_top_valid, latency 1.
REQ-026 WS_MAC: when in_left_valid and in_top_valid, out_down <= in_top + product and out_down_valid <= 1; otherwise out_down holds and out_down_valid <= 0.
REQ-027 OS_ACC: in_left_valid SHALL update acc <= acc + product; out_down_valid <= 0 unless draining.
REQ-028 OS_ACC drain SHALL set out_down <= acc (pre-update value) and out_down_valid <= 1; acc <= product if in_left_valid, else 0.
REQ-029 acc_clear SHALL have priority over accumulate and drain: acc <= 0, ovf <= 0, and no drain output is produced.
REQ-030 A mode change SHALL take effect at the next edge; acc and weights are retained across mode changes.
REQ-031 The product SHALL always use the active weight as it was before the current edge; a swap in the same cycle affects the next cycle only.

Reset
REQ-032 reset SHALL zero out_right, out_right_valid, out_down, out_down_valid, shadow, active, shadow_full, acc and ovf, overriding all other inputs including mid-operation.

Structure
REQ-033 Shared package pe_pkg SHALL hold the mode encodings (PE_PASS, PE_WS_MAC, PE_OS_ACC) and the default widths.
REQ-034 Signed add-with-saturate SHALL be one combinational sub-module, pe_sat_add, instanced for both the WS_MAC and OS_ACC sums.

Verification
REQ-035 Load 3, swap, WS_MAC, in_left=4, in_top=10, both valid: out_down=22 and out_down_valid=1 one cycle later.
REQ-036 Load 5 then load 7 with no swap, then swap: active=7, shadow_full=0; a second swap leaves active=7.
REQ-037 OS_ACC, weight 2, in_left 1, 2, 3 valid, then drain: out_down=12, then acc=0, out_down_valid=1 for one cycle.
REQ-038 SATURATE=1, WS_MAC, in_top=0x7FFFFFF0, weight 0x7FFF, in_left 0x7FFF: out_down=0x7FFFFFFF and ovf=1; acc_clear then sets ovf=0.
REQ-039 Reset asserted mid-accumulation with weight_load high: all outputs 0 and shadow_full=0 next cycle.
REQ-040 PASS with in_top=0xABCD, in_top_valid=1, in_left=9: out_down=0xABCD and out_right=9 after one cycle.
